// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulator arbiter.
// State encoding, default datapath width and id width.
package acc_pkg;

  localparam int ACC_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or
// above the pointer, wrapping around.
import acc_pkg::*;

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);

  always_comb begin
    gnt = '0;
    id  = '0;
    any = |req;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        id       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/acc_arbiter.sv
// Shares one accumulator between NREQ burst requesters:
// grant, clear, stream, wait latency, return tagged sum.
import acc_pkg::*;

module acc_arbiter #(
  parameter int W         = ACC_W,
  parameter int NREQ      = 4,
  parameter int IDW       = id_width(NREQ),
  parameter int ACC_LAT   = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_data,
  output logic              res_trunc,
  input  logic              res_ready,
  output logic              acc_clr,
  output logic              acc_vaild,
  output logic [W-1:0]      acc_in,
  input  logic [W-1:0]      acc_out
);

  localparam int BCW = $clog2(MAX_BEATS + 1);
  localparam int WCW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

  state_t          st_q, st_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0] oh_q, oh_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [BCW-1:0]  cnt_q, cnt_d;
  logic [WCW-1:0]  wt_q, wt_d;
  logic            trunc_q, trunc_d;
  logic [IDW-1:0]  rid_q, rid_d;
  logic [W-1:0]    rdat_q, rdat_d;
  logic            rtr_q, rtr_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_id;
  logic            arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

  assign res_id    = rid_q;
  assign res_data  = rdat_q;
  assign res_trunc = rtr_q;

  always_comb begin
    st_d      = st_q;
    gnt_d     = gnt_q;
    oh_d      = oh_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wt_d      = wt_q;
    trunc_d   = trunc_q;
    rid_d     = rid_q;
    rdat_d    = rdat_q;
    rtr_d     = rtr_q;
    req_ready = '0;
    acc_clr   = 1'b0;
    acc_vaild = 1'b0;
    acc_in    = '0;
    res_valid = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d = arb_id;
          oh_d  = arb_gnt;
          st_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        acc_clr = 1'b1;
        cnt_d   = '0;
        st_d    = ST_RUN;
      end
      ST_RUN: begin
        req_ready = oh_q;
        acc_vaild = req_valid[gnt_q];
        if (acc_vaild) begin
          acc_in = req_data[gnt_q*W +: W];
          cnt_d  = cnt_q + 1'b1;
          wt_d   = '0;
          if (req_last[gnt_q]) begin
            trunc_d = 1'b0;
            st_d    = ST_WAIT;
          end else if (cnt_q == BCW'(MAX_BEATS - 1)) begin
            trunc_d = 1'b1;
            st_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wt_q == WCW'(ACC_LAT - 1)) begin
          rdat_d = acc_out;
          rtr_d  = trunc_q;
          rid_d  = gnt_q;
          st_d   = ST_RESP;
        end else begin
          wt_d = wt_q + 1'b1;
        end
      end
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          ptr_d = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          st_d  = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= ST_IDLE;
      gnt_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wt_q    <= '0;
      trunc_q <= 1'b0;
      rid_q   <= '0;
      rdat_q  <= '0;
      rtr_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      gnt_q   <= gnt_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wt_q    <= wt_d;
      trunc_q <= trunc_d;
      rid_q   <= rid_d;
      rdat_q  <= rdat_d;
      rtr_q   <= rtr_d;
    end
  end

endmodule

// File: tb/tb_acc_arbiter.sv
// Scoreboard bench for acc_arbiter with a latency-2
// accumulator model and per-requester burst queues.
module tb_acc_arbiter;

  localparam int W         = 8;
  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int ACC_LAT   = 2;
  localparam int MAX_BEATS = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    int sum;
    bit trunc;
    int beats;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_data;
  logic              res_trunc;
  logic              res_ready;
  logic              acc_clr;
  logic              acc_vaild;
  logic [W-1:0]      acc_in;
  logic [W-1:0]      acc_out;

  acc_arbiter #(
    .W         (W),
    .NREQ      (NREQ),
    .IDW       (IDW),
    .ACC_LAT   (ACC_LAT),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_trunc (res_trunc),
    .res_ready (res_ready),
    .acc_clr   (acc_clr),
    .acc_vaild (acc_vaild),
    .acc_in    (acc_in),
    .acc_out   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator instance model: one register plus one
  // output stage gives a settled value two cycles later.
  logic [W-1:0] acc_int, acc_d;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_int <= '0;
      acc_d   <= '0;
    end else begin
      if (acc_clr) acc_int <= '0;
      else if (acc_vaild) acc_int <= acc_int + acc_in;
      acc_d <= acc_int;
    end
  end
  assign acc_out = acc_d;

  beat_t bq[NREQ][$];
  exp_t  eq[NREQ][$];
  int    part_sum[NREQ];
  int    part_cnt[NREQ];
  int    acc_cnt[NREQ];
  bit    stall[NREQ];
  bit    rr_rand;
  int    checks;
  int    errors;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Queue a burst and derive its expected results from the
  // chunking rule: a chunk ends on last or at MAX_BEATS.
  task automatic send(input int r, input int n, input int base,
                      input int stp, input bit last_end);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      b.d = W'(base + k * stp);
      b.l = last_end && (k == n - 1);
      bq[r].push_back(b);
      part_sum[r] = (part_sum[r] + int'(b.d)) % 256;
      part_cnt[r]++;
      if (b.l || part_cnt[r] == MAX_BEATS) begin
        e.sum   = part_sum[r];
        e.trunc = !b.l;
        e.beats = part_cnt[r];
        eq[r].push_back(e);
        part_sum[r] = 0;
        part_cnt[r] = 0;
      end
    end
  endtask

  function automatic int pending();
    int p;
    p = 0;
    for (int i = 0; i < NREQ; i++)
      p += bq[i].size() + eq[i].size();
    return p;
  endfunction

  task automatic drain();
    int t;
    t = 0;
    while (pending() != 0 && t < 3000) begin
      step();
      t++;
    end
    if (pending() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d items left, expected 0",
               pending());
    end
  endtask

  task automatic wait_acc(input int r, input int n);
    int t;
    t = 0;
    while (acc_cnt[r] < n && t < 500) begin
      step();
      t++;
    end
    if (acc_cnt[r] < n) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got %0d beats, expected %0d",
               acc_cnt[r], n);
    end
  endtask

  task automatic wait_res();
    int t;
    t = 0;
    while (!res_valid && t < 500) begin
      step();
      t++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL res_timeout: got res_valid 0, expected 1");
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_trunc"}, res_trunc, 0);
    chk({tag, "_acc_clr"}, acc_clr, 0);
    chk({tag, "_acc_vaild"}, acc_vaild, 0);
    chk({tag, "_acc_in"}, acc_in, 0);
  endtask

  // Requester drivers: present queue heads, pop on handshake.
  initial begin
    bit hs[NREQ];
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        hs[i] = rst && req_valid[i] && req_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] && bq[i].size() > 0) begin
          void'(bq[i].pop_front());
          acc_cnt[i]++;
        end
        if (bq[i].size() > 0 && !stall[i]) begin
          req_valid[i]      = 1'b1;
          req_data[i*W +: W] = bq[i][0].d;
          req_last[i]       = bq[i][0].l;
        end else begin
          req_valid[i]      = 1'b0;
          req_data[i*W +: W] = '0;
          req_last[i]       = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: protocol checks plus scoreboard pop per result.
  initial begin
    logic [NREQ-1:0] pv;
    logic [IDW-1:0]  hid;
    logic [W-1:0]    hdat;
    logic            htr;
    logic [W-1:0]    ex_in;
    int              mptr, eg, cur_g, seen;
    bit              pend, hold, found;
    exp_t            e;
    pv = '0; mptr = 0; eg = 0; cur_g = 0; seen = 0;
    pend = 0; hold = 0;
    hid = '0; hdat = '0; htr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = '0; mptr = 0; pend = 0; hold = 0; seen = 0;
        continue;
      end
      chk("ready_onehot", $countones(req_ready) <= 1, 1);
      if (res_valid) chk("ready_in_resp", req_ready, 0);
      ex_in = '0;
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) ex_in = req_data[i*W +: W];
      chk("acc_vaild", acc_vaild, |(req_valid & req_ready));
      chk("acc_in", acc_in, ex_in);
      if (pend) begin
        chk("grant", req_ready, 1 << eg);
        pend = 0;
      end
      if (acc_clr) begin
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && pv[(mptr + k) % NREQ]) begin
            eg    = (mptr + k) % NREQ;
            found = 1;
          end
        end
        chk("clr_had_request", found, 1);
        cur_g = eg;
        pend  = 1;
        seen  = 0;
      end else if (acc_vaild) begin
        seen++;
      end
      if (hold) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_id", res_id, hid);
        chk("hold_data", res_data, hdat);
        chk("hold_trunc", res_trunc, htr);
      end
      hold = res_valid && !res_ready;
      hid  = res_id;
      hdat = res_data;
      htr  = res_trunc;
      if (res_valid && res_ready) begin
        chk("res_id", res_id, cur_g);
        if (eq[res_id].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id %0d data %0d, expected none",
                   res_id, res_data);
        end else begin
          e = eq[res_id].pop_front();
          chk("res_data", res_data, e.sum);
          chk("res_trunc", res_trunc, e.trunc);
          chk("beats", seen, e.beats);
        end
        mptr = (int'(res_id) + 1) % NREQ;
      end
      pv = req_valid;
    end
  end

  initial begin
    int r, n;
    checks = 0;
    errors = 0;
    rr_rand = 0;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      part_sum[i] = 0; part_cnt[i] = 0;
      acc_cnt[i] = 0; stall[i] = 0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero_outs("reset");
    rst = 1'b1;
    step();

    send(1, 2, 3, 1, 1);
    send(3, 1, 9, 0, 1);
    drain();
    for (int i = 0; i < NREQ; i++) send(i, 1, i + 1, 0, 1);
    drain();

    send(0, 4, 5, 5, 1);
    drain();
    send(2, 2, 200, -100, 1);
    drain();

    send(0, 17, 1, 0, 0);
    send(0, 1, 2, 0, 1);
    drain();

    res_ready = 1'b0;
    send(1, 5, 1, 1, 1);
    wait_acc(1, 2);
    stall[1] = 1;
    repeat (3) step();
    stall[1] = 0;
    wait_res();
    send(2, 1, 7, 0, 1);
    repeat (5) step();
    res_ready = 1'b1;
    drain();

    rr_rand = 1;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, NREQ - 1);
      n = $urandom_range(1, 20);
      send(r, n, $urandom_range(0, 255), $urandom_range(0, 255), 1);
      if (it % 8 == 7) drain();
    end
    drain();
    rr_rand = 0;
    step();
    res_ready = 1'b1;

    send(1, 1, 1, 0, 1);
    drain();
    send(2, 5, 10, 1, 1);
    wait_acc(2, 2);
    rst = 1'b0;
    #1;
    chk_zero_outs("midrst");
    for (int i = 0; i < NREQ; i++) begin
      bq[i].delete();
      eq[i].delete();
      part_sum[i] = 0; part_cnt[i] = 0;
      acc_cnt[i] = 0; stall[i] = 0;
    end
    repeat (2) step();
    rst = 1'b1;
    step();
    send(0, 1, 1, 0, 1);
    send(3, 1, 2, 0, 1);
    drain();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
